// File: rtl/riscv_pkg.sv
// Shared decode constants, enums and helpers for the single-cycle RV32I core.
`timescale 1ns/1ps
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // addi x0,x0,0: what the core reports while an external fetch is pending
  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } aluOp_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} immFmt_t;

  // Sign-extended immediate for the given RV32I encoding format
  function automatic logic [31:0] immGen(input logic [31:0] ins, input immFmt_t fmt);
    case (fmt)
      IMM_I:   immGen = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   immGen = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   immGen = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   immGen = {ins[31:12], 12'b0};
      IMM_J:   immGen = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: immGen = '0;
    endcase
  endfunction

  // 32-bit wrap-around ALU; shifts use only the low 5 bits of b
  function automatic logic [31:0] aluCalc(input aluOp_t op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      ALU_ADD:  aluCalc = a + b;
      ALU_SUB:  aluCalc = a - b;
      ALU_SLL:  aluCalc = a << b[4:0];
      ALU_SLT:  aluCalc = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: aluCalc = {31'b0, a < b};
      ALU_XOR:  aluCalc = a ^ b;
      ALU_SRL:  aluCalc = a >> b[4:0];
      ALU_SRA:  aluCalc = 32'($signed(a) >>> b[4:0]);
      ALU_OR:   aluCalc = a | b;
      ALU_AND:  aluCalc = a & b;
      default:  aluCalc = a + b;
    endcase
  endfunction

endpackage

// File: rtl/riscv_ins.sv
// Instruction fetch: pc register, internal instruction ROM and external fetch port.
`timescale 1ns/1ps
module riscv_rom #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] rAddr,
  output logic [31:0]   rData,
  input  logic          wEn,
  input  logic [AW-1:0] wAddr,
  input  logic [31:0]   wData
);

  reg [31:0] mem [0:WORDS-1];

  assign rData = mem[rAddr];

  // Load port kept for image preload; tied off in the instruction path
  always_ff @(posedge clk) begin
    if (wEn) mem[wAddr] <= wData;
  end

endmodule

module riscv_imem #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);

  riscv_rom #(.WORDS(WORDS), .AW(AW)) mem1 (
    .clk(clk), .rAddr(addr), .rData(data),
    .wEn(1'b0), .wAddr('0), .wData('0)
  );

endmodule

module riscv_ins
  import riscv_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] nextPc,
  input  logic        exIns_valid,
  input  logic [31:0] exIns_in,
  output logic        exIns_ren,
  output logic [31:0] exIns_addr,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        stall
);

  localparam int          AW         = $clog2(IMEM_WORDS);
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

  logic        isExt;
  logic [31:0] romData;

  riscv_imem #(.WORDS(IMEM_WORDS), .AW(AW)) imem (
    .clk(clk), .addr(pc[AW+1:2]), .data(romData)
  );

  // External fetch handshake: exIns_ren is a request held (with exIns_addr=pc) for as
  // long as pc sits above the internal ROM. exIns_valid acts as the response strobe: the
  // word on exIns_in executes in a cycle with exIns_valid=1 and retires at the next edge.
  // While exIns_valid=0, exIns_in is ignored, pc holds and the core executes a NOP.
  assign isExt      = (pc >= IMEM_BYTES);
  assign stall      = isExt && !exIns_valid;
  assign exIns_ren  = isExt;
  assign exIns_addr = pc;
  assign inst       = !isExt ? romData : (exIns_valid ? exIns_in : NOP_INST);

  // Program counter: reset vector, hold while the external fetch is pending
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)       pc <= RESET_PC;
    else if (!stall) pc <= nextPc;
  end

endmodule

// File: rtl/riscv_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one write port.
`timescale 1ns/1ps
module riscv_regfile (
  input  logic        clk,
  input  logic        nrst,
  input  logic [4:0]  rAddr1,
  input  logic [4:0]  rAddr2,
  output logic [31:0] rData1,
  output logic [31:0] rData2,
  input  logic        wEn,
  input  logic [4:0]  wAddr,
  input  logic [31:0] wData
);

  logic [31:0] regs [0:31];

  // x0 is hard-wired to zero on the read side and is never written
  assign rData1 = (rAddr1 == 5'd0) ? 32'd0 : regs[rAddr1];
  assign rData2 = (rAddr2 == 5'd0) ? 32'd0 : regs[rAddr2];

  // Clear all registers on reset; retire one write per clock otherwise
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wEn && (wAddr != 5'd0)) begin
      regs[wAddr] <= wData;
    end
  end

endmodule

// File: rtl/riscv_core.sv
// Single-cycle RV32I core: fetch unit, inline decode/execute, register file, data RAM.
`timescale 1ns/1ps
module riscv_core
  import riscv_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        exIns_valid,
  input  logic [31:0] exIns_in,
  output logic        exIns_ren,
  output logic [31:0] exIns_addr,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  localparam int DAW = $clog2(DMEM_WORDS);

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] rs1Val, rs2Val, pcPlus4, nextPc, wbData, memAddr, memRdata;
  logic        stall, rdWe, memWe, take, unusedAddrBits;
  aluOp_t      aluOp;
  logic [31:0] dmem [0:DMEM_WORDS-1];

  riscv_ins #(.IMEM_WORDS(IMEM_WORDS), .RESET_PC(RESET_PC)) ins_mod (
    .clk(clk), .nrst(nrst), .nextPc(nextPc),
    .exIns_valid(exIns_valid), .exIns_in(exIns_in),
    .exIns_ren(exIns_ren), .exIns_addr(exIns_addr),
    .pc(pc), .inst(inst), .stall(stall)
  );

  riscv_regfile regFile (
    .clk(clk), .nrst(nrst),
    .rAddr1(rs1), .rAddr2(rs2), .rData1(rs1Val), .rData2(rs2Val),
    .wEn(rdWe && !stall), .wAddr(rd), .wData(wbData)
  );

  assign opcode  = inst[6:0];
  assign rd      = inst[11:7];
  assign funct3  = inst[14:12];
  assign rs1     = inst[19:15];
  assign rs2     = inst[24:20];
  assign funct7  = inst[31:25];
  assign pcPlus4 = pc + 32'd4;

  // Word-addressed data RAM; low address bits and bits above the RAM are ignored
  assign memAddr        = rs1Val + immGen(inst, (opcode == OP_STORE) ? IMM_S : IMM_I);
  assign memRdata       = dmem[memAddr[DAW+1:2]];
  assign unusedAddrBits = ^{memAddr[31:DAW+2], memAddr[1:0]};

  // Decode and execute: writeback value, write enables and next pc
  always_comb begin
    rdWe   = 1'b0;
    memWe  = 1'b0;
    wbData = '0;
    nextPc = pcPlus4;
    aluOp  = ALU_ADD;
    take   = 1'b0;
    case (opcode)
      OP_LUI: begin
        rdWe   = 1'b1;
        wbData = immGen(inst, IMM_U);
      end
      OP_AUIPC: begin
        rdWe   = 1'b1;
        wbData = pc + immGen(inst, IMM_U);
      end
      OP_JAL: begin
        rdWe   = 1'b1;
        wbData = pcPlus4;
        nextPc = pc + immGen(inst, IMM_J);
      end
      OP_JALR: if (funct3 == 3'd0) begin
        rdWe   = 1'b1;
        wbData = pcPlus4;
        nextPc = (rs1Val + immGen(inst, IMM_I)) & ~32'd1;
      end
      OP_BRANCH: begin
        case (funct3)
          3'd0:    take = (rs1Val == rs2Val);
          3'd1:    take = (rs1Val != rs2Val);
          3'd4:    take = ($signed(rs1Val) <  $signed(rs2Val));
          3'd5:    take = ($signed(rs1Val) >= $signed(rs2Val));
          3'd6:    take = (rs1Val <  rs2Val);
          3'd7:    take = (rs1Val >= rs2Val);
          default: take = 1'b0;
        endcase
        if (take) nextPc = pc + immGen(inst, IMM_B);
      end
      OP_LOAD: if (funct3 == 3'd2) begin
        rdWe   = 1'b1;
        wbData = memRdata;
      end
      OP_STORE: memWe = (funct3 == 3'd2);
      OP_IMM: begin
        rdWe = 1'b1;
        case (funct3)
          3'd0: aluOp = ALU_ADD;
          3'd1: begin aluOp = ALU_SLL; rdWe = (funct7 == 7'h00); end
          3'd2: aluOp = ALU_SLT;
          3'd3: aluOp = ALU_SLTU;
          3'd4: aluOp = ALU_XOR;
          3'd5: begin
            aluOp = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
            rdWe  = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
          3'd6: aluOp = ALU_OR;
          default: aluOp = ALU_AND;
        endcase
        wbData = aluCalc(aluOp, rs1Val, immGen(inst, IMM_I));
      end
      OP_REG: begin
        rdWe = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'd0}: aluOp = ALU_ADD;
          {7'h20, 3'd0}: aluOp = ALU_SUB;
          {7'h00, 3'd1}: aluOp = ALU_SLL;
          {7'h00, 3'd2}: aluOp = ALU_SLT;
          {7'h00, 3'd3}: aluOp = ALU_SLTU;
          {7'h00, 3'd4}: aluOp = ALU_XOR;
          {7'h00, 3'd5}: aluOp = ALU_SRL;
          {7'h20, 3'd5}: aluOp = ALU_SRA;
          {7'h00, 3'd6}: aluOp = ALU_OR;
          {7'h00, 3'd7}: aluOp = ALU_AND;
          default:       rdWe  = 1'b0;
        endcase
        wbData = aluCalc(aluOp, rs1Val, rs2Val);
      end
      default: ;
    endcase
  end

  // Data RAM write; contents survive reset
  always_ff @(posedge clk) begin
    if (memWe && !stall && nrst) dmem[memAddr[DAW+1:2]] <= rs2Val;
  end

endmodule

// File: tb/tb_riscv_core.sv
`timescale 1ns/1ps
module tb_riscv_core;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        nrst;
  logic        exIns_valid;
  logic [31:0] exIns_in;
  logic        exIns_ren;
  logic [31:0] exIns_addr;
  logic [31:0] pc;
  logic [31:0] inst;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] prog [0:18];

  riscv_core dut (
    .clk(clk), .nrst(nrst),
    .exIns_valid(exIns_valid), .exIns_in(exIns_in),
    .exIns_ren(exIns_ren), .exIns_addr(exIns_addr),
    .pc(pc), .inst(inst)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #1 clk = ~clk;
  end

  initial begin
    #5000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task load_program();
    prog = '{32'h00500093, 32'h00108133, 32'h40110233, 32'h00202023, 32'h00000463,
             32'h00100293, 32'h00C000EF, 32'h00100293, 32'h00100293, 32'h00002183,
             32'h00700013, 32'hFFFFFFFF, 32'hFF000493, 32'h4024D513, 32'h0090B5B3,
             32'h0014A633, 32'h0044D6B3, 32'h00001337, 32'h000303E7};
    for (int i = 0; i < 64; i++) dut.ins_mod.imem.mem1.mem[i] <= NOP;
    for (int i = 0; i < 19; i++) dut.ins_mod.imem.mem1.mem[i] <= prog[i];
  endtask

  task test_reset();
    nrst = 1'b1; exIns_valid = 1'b0; exIns_in = '0;
    load_program();
    #1 nrst = 1'b0;
    #1;
    tests_run++;
    if (pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    tests_run++;
    if (exIns_ren !== 1'b0) begin tests_failed++; $display("FAIL reset_ren: got %b expected 0", exIns_ren); end
    @(negedge clk);
    nrst = 1'b1;
    #0.1;
    tests_run++;
    if (inst !== prog[0]) begin tests_failed++; $display("FAIL reset_first_inst: got %h expected %h", inst, prog[0]); end
  endtask

  task test_internal_program();
    int trace [16] = '{0, 1, 2, 3, 4, 6, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18};
    logic [31:0] exp_regs [0:13] = '{32'h0, 32'h1C, 32'd10, 32'd10, 32'd5, 32'h0, 32'h1000,
                                     32'h4C, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFC, 32'h1, 32'h1,
                                     32'h07FFFFFF};
    logic [31:0] ep, ei;
    for (int i = 0; i < 16; i++) begin
      exp_pc_q.push_back(32'(trace[i] * 4));
      exp_inst_q.push_back(prog[trace[i]]);
    end
    while (exp_pc_q.size() > 0) begin
      ep = exp_pc_q.pop_front();
      ei = exp_inst_q.pop_front();
      tests_run++;
      if (pc !== ep) begin tests_failed++; $display("FAIL int_pc: got %h expected %h", pc, ep); end
      tests_run++;
      if (inst !== ei) begin tests_failed++; $display("FAIL int_inst at pc %h: got %h expected %h", ep, inst, ei); end
      tests_run++;
      if (exIns_ren !== 1'b0) begin tests_failed++; $display("FAIL int_ren at pc %h: got %b expected 0", ep, exIns_ren); end
      @(negedge clk); #0.1;
    end
    for (int r = 0; r < 14; r++) begin
      tests_run++;
      if (dut.regFile.regs[r] !== exp_regs[r]) begin
        tests_failed++;
        $display("FAIL int_reg x%0d: got %h expected %h", r, dut.regFile.regs[r], exp_regs[r]);
      end
    end
    tests_run++;
    if (dut.dmem[0] !== 32'd10) begin tests_failed++; $display("FAIL int_dmem0: got %h expected %h", dut.dmem[0], 32'd10); end
  endtask

  task test_external_fetch();
    logic [31:0] ep, ei;
    for (int c = 0; c < 4; c++) begin
      exIns_valid = (c == 3);
      exIns_in    = (c == 3) ? 32'h00100093 : 32'h00500293;
      exp_pc_q.push_back(32'h1000);
      exp_inst_q.push_back((c == 3) ? 32'h00100093 : NOP);
      #0.1;
      ep = exp_pc_q.pop_front();
      ei = exp_inst_q.pop_front();
      tests_run++;
      if (pc !== ep) begin tests_failed++; $display("FAIL ext_pc cycle %0d: got %h expected %h", c, pc, ep); end
      tests_run++;
      if (inst !== ei) begin tests_failed++; $display("FAIL ext_inst cycle %0d: got %h expected %h", c, inst, ei); end
      tests_run++;
      if (exIns_ren !== 1'b1 || exIns_addr !== 32'h1000) begin
        tests_failed++;
        $display("FAIL ext_req cycle %0d: got ren=%b addr=%h expected ren=1 addr=00001000", c, exIns_ren, exIns_addr);
      end
      tests_run++;
      if (dut.regFile.regs[1] !== 32'h1C || dut.regFile.regs[5] !== 32'h0) begin
        tests_failed++;
        $display("FAIL ext_hold_regs cycle %0d: got x1=%h x5=%h expected x1=0000001c x5=00000000",
                 c, dut.regFile.regs[1], dut.regFile.regs[5]);
      end
      @(negedge clk); #0.1;
    end
    exIns_valid = 1'b0;
    tests_run++;
    if (pc !== 32'h1004) begin tests_failed++; $display("FAIL ext_retire_pc: got %h expected %h", pc, 32'h1004); end
    tests_run++;
    if (dut.regFile.regs[1] !== 32'h1) begin tests_failed++; $display("FAIL ext_retire_x1: got %h expected %h", dut.regFile.regs[1], 32'h1); end
  endtask

  task test_back_to_back();
    logic [31:0] words [2] = '{32'h00000463, 32'h00308713};
    logic [31:0] ep, ei;
    exp_pc_q.push_back(32'h1004); exp_inst_q.push_back(words[0]);
    exp_pc_q.push_back(32'h100C); exp_inst_q.push_back(words[1]);
    for (int c = 0; c < 2; c++) begin
      exIns_valid = 1'b1;
      exIns_in    = words[c];
      #0.1;
      ep = exp_pc_q.pop_front();
      ei = exp_inst_q.pop_front();
      tests_run++;
      if (pc !== ep || exIns_addr !== ep) begin
        tests_failed++;
        $display("FAIL b2b_pc cycle %0d: got pc=%h addr=%h expected %h", c, pc, exIns_addr, ep);
      end
      tests_run++;
      if (inst !== ei) begin tests_failed++; $display("FAIL b2b_inst cycle %0d: got %h expected %h", c, inst, ei); end
      @(negedge clk); #0.1;
    end
    exIns_valid = 1'b0;
    tests_run++;
    if (pc !== 32'h1010) begin tests_failed++; $display("FAIL b2b_final_pc: got %h expected %h", pc, 32'h1010); end
    tests_run++;
    if (dut.regFile.regs[14] !== 32'h4) begin tests_failed++; $display("FAIL b2b_x14: got %h expected %h", dut.regFile.regs[14], 32'h4); end
  endtask

  task test_reset_mid_stall();
    exIns_valid = 1'b0;
    exIns_in    = 32'h00500293;
    #0.1;
    tests_run++;
    if (exIns_ren !== 1'b1 || inst !== NOP) begin
      tests_failed++;
      $display("FAIL stall_before_reset: got ren=%b inst=%h expected ren=1 inst=%h", exIns_ren, inst, NOP);
    end
    #0.3 nrst = 1'b0;
    #0.1;
    tests_run++;
    if (pc !== 32'h0 || exIns_ren !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_on_reset: got pc=%h ren=%b expected pc=00000000 ren=0", pc, exIns_ren);
    end
    @(negedge clk);
    nrst = 1'b1;
    #0.1;
    tests_run++;
    if (pc !== 32'h0 || inst !== prog[0]) begin
      tests_failed++;
      $display("FAIL rereset_fetch: got pc=%h inst=%h expected pc=00000000 inst=%h", pc, inst, prog[0]);
    end
    tests_run++;
    if (dut.regFile.regs[1] !== 32'h0 || dut.regFile.regs[14] !== 32'h0) begin
      tests_failed++;
      $display("FAIL rereset_regs: got x1=%h x14=%h expected 0", dut.regFile.regs[1], dut.regFile.regs[14]);
    end
    tests_run++;
    if (dut.dmem[0] !== 32'd10) begin tests_failed++; $display("FAIL rereset_dmem0: got %h expected %h", dut.dmem[0], 32'd10); end
    @(negedge clk); #0.1;
    tests_run++;
    if (pc !== 32'h4) begin tests_failed++; $display("FAIL rereset_step: got %h expected %h", pc, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_internal_program();
    test_external_fetch();
    test_back_to_back();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
